// File: rtl/single_bit_sync_if.sv
`default_nettype none
// ============================================================================
// Module      : single_bit_sync_if
// Description : Signal bundle for the single-bit level synchronizer. The
//               master side drives the source-domain level and observes the
//               synchronized level and its edge strobes; the slave side is
//               the synchronizer itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface single_bit_sync_if;
    logic signal_a;       // source-domain level, driven straight from a flop
    logic signal_b;       // synchronized level in the destination domain
    logic signal_b_rise;  // one-cycle strobe on a 0->1 change of signal_b
    logic signal_b_fall;  // one-cycle strobe on a 1->0 change of signal_b

    modport master (
        output signal_a,
        input  signal_b,
        input  signal_b_rise,
        input  signal_b_fall
    );

    modport slave (
        input  signal_a,
        output signal_b,
        output signal_b_rise,
        output signal_b_fall
    );
endinterface
`default_nettype wire

// File: rtl/single_bit_sync.sv
`default_nettype none
// ============================================================================
// Module      : single_bit_sync
// Description : Multi-flop level synchronizer carrying one quasi-static bit
//               into the clk_b domain, with single-cycle rise/fall strobes
//               derived purely from flop outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module single_bit_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VALUE = 1'b0
) (
    input wire               clk_b,
    input wire               rst_n,
    single_bit_sync_if.slave sync_if
);

    // A chain shorter than two flops gives no metastability resolution time.
    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 8) begin : g_bad_stages
            $error("single_bit_sync: SYNC_STAGES must be in the range 2..8");
        end
    endgenerate

    // Synchronizer chain; bit 0 is the only flop that sees signal_a. The
    // attribute keeps the cells adjacent and free from retiming/duplication.
    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] r_sync;
    logic                                            r_prev_b;
    logic                                            w_signal_b;

    assign w_signal_b = r_sync[SYNC_STAGES-1];

    // Shift signal_a through the chain with no logic between stages.
    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{RESET_VALUE}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sync_if.signal_a};
        end
    end

    // History of the synchronized level for edge detection.
    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_b <= RESET_VALUE;
        end else begin
            r_prev_b <= w_signal_b;
        end
    end

    // Strobes depend only on flop outputs, so they never see signal_a
    // directly and cannot both be high at once.
    assign sync_if.signal_b      = w_signal_b;
    assign sync_if.signal_b_rise = w_signal_b & ~r_prev_b;
    assign sync_if.signal_b_fall = ~w_signal_b & r_prev_b;

endmodule
`default_nettype wire

// File: tb/tb_single_bit_sync.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_single_bit_sync
// Description : Self-checking bench for single_bit_sync. Two instances: the
//               default 2-stage/reset-0 build and a 3-stage/reset-1 build.
//               A delay-line scoreboard per instance predicts every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_single_bit_sync;

    logic clk_b;
    logic rst0_n;
    logic rst1_n;

    int n_checks = 0;
    int n_fail   = 0;

    // Observed strobe counts, stepped by the monitors.
    int rise0 = 0;
    int fall0 = 0;
    int rise1 = 0;
    int fall1 = 0;

    single_bit_sync_if if0 ();
    single_bit_sync_if if1 ();

    single_bit_sync #(
        .SYNC_STAGES (2),
        .RESET_VALUE (1'b0)
    ) u_dut0 (
        .clk_b   (clk_b),
        .rst_n   (rst0_n),
        .sync_if (if0.slave)
    );

    single_bit_sync #(
        .SYNC_STAGES (3),
        .RESET_VALUE (1'b1)
    ) u_dut1 (
        .clk_b   (clk_b),
        .rst_n   (rst1_n),
        .sync_if (if1.slave)
    );

    // 30 ns period, rising edges at 15, 45, 75, ...
    initial begin
        clk_b = 1'b0;
        forever #15 clk_b = ~clk_b;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    // Scoreboard for instance 0: the value sampled at each edge is pushed,
    // the value leaving the far end of the 2-deep line is the expected level.
    initial begin : p_mon0
        bit pipe[$];
        bit exp_b;
        bit exp_prev;
        bit a_s;
        for (int i = 0; i < 2; i++) pipe.push_back(1'b0);
        exp_b    = 1'b0;
        exp_prev = 1'b0;
        forever begin
            @(posedge clk_b or negedge rst0_n);
            a_s = if0.signal_a;
            if (!rst0_n) begin
                pipe.delete();
                for (int i = 0; i < 2; i++) pipe.push_back(1'b0);
                exp_b    = 1'b0;
                exp_prev = 1'b0;
            end else begin
                exp_prev = exp_b;
                void'(pipe.pop_front());
                pipe.push_back(a_s);
                exp_b = pipe[0];
            end
            #1;
            check("d0_b",    32'(if0.signal_b),      32'(exp_b));
            check("d0_rise", 32'(if0.signal_b_rise), 32'(exp_b & ~exp_prev));
            check("d0_fall", 32'(if0.signal_b_fall), 32'(~exp_b & exp_prev));
            check("d0_excl", 32'(if0.signal_b_rise & if0.signal_b_fall), 32'(0));
            if (if0.signal_b_rise) rise0++;
            if (if0.signal_b_fall) fall0++;
        end
    end

    // Scoreboard for instance 1: 3-deep line, reset value 1.
    initial begin : p_mon1
        bit pipe[$];
        bit exp_b;
        bit exp_prev;
        bit a_s;
        for (int i = 0; i < 3; i++) pipe.push_back(1'b1);
        exp_b    = 1'b1;
        exp_prev = 1'b1;
        forever begin
            @(posedge clk_b or negedge rst1_n);
            a_s = if1.signal_a;
            if (!rst1_n) begin
                pipe.delete();
                for (int i = 0; i < 3; i++) pipe.push_back(1'b1);
                exp_b    = 1'b1;
                exp_prev = 1'b1;
            end else begin
                exp_prev = exp_b;
                void'(pipe.pop_front());
                pipe.push_back(a_s);
                exp_b = pipe[0];
            end
            #1;
            check("d1_b",    32'(if1.signal_b),      32'(exp_b));
            check("d1_rise", 32'(if1.signal_b_rise), 32'(exp_b & ~exp_prev));
            check("d1_fall", 32'(if1.signal_b_fall), 32'(~exp_b & exp_prev));
            if (if1.signal_b_rise) rise1++;
            if (if1.signal_b_fall) fall1++;
        end
    end

    initial begin : p_stim
        int snap_r;
        int snap_f;

        rst0_n       = 1'b0;
        rst1_n       = 1'b0;
        if0.signal_a = 1'b0;
        if1.signal_a = 1'b0;

        // Reset held while signal_a toggles, then the basic sequence.
        #5  if0.signal_a = 1'b1;
        #5  if0.signal_a = 1'b0;
        #10 if0.signal_a = 1'b1;
        #2  if0.signal_a = 1'b0;
        #3  if0.signal_a = 1'b1;                          // t=25
        #5  check("rst_b", 32'(if0.signal_b), 32'(0));    // t=30
        #10 rst0_n = 1'b1;                                // t=40
        #25 if0.signal_a = 1'b0;                          // t=65
        #11 check("rise_75_b", 32'(if0.signal_b), 32'(1));        // t=76
        check("rise_75_s", 32'(if0.signal_b_rise), 32'(1));
        #19 if0.signal_a = 1'b1;                          // t=95
        #11 check("fall_105_b", 32'(if0.signal_b), 32'(0));       // t=106
        check("fall_105_s", 32'(if0.signal_b_fall), 32'(1));
        #30 check("rise_135_b", 32'(if0.signal_b), 32'(1));       // t=136
        check("rise_135_s", 32'(if0.signal_b_rise), 32'(1));

        // Short pulse between edges must vanish.
        @(posedge clk_b); #10 if0.signal_a = 1'b0;
        repeat (4) @(posedge clk_b);
        snap_r = rise0;
        snap_f = fall0;
        @(posedge clk_b); #8 if0.signal_a = 1'b1;
        #5 if0.signal_a = 1'b0;
        repeat (4) @(posedge clk_b);
        #2;
        check("short_b",    32'(if0.signal_b), 32'(0));
        check("short_rise", 32'(rise0 - snap_r), 32'(0));
        check("short_fall", 32'(fall0 - snap_f), 32'(0));

        // Max-rate toggling: one strobe per transition, nothing merged.
        snap_r = rise0;
        snap_f = fall0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_b); #10 if0.signal_a = ~if0.signal_a;
        end
        repeat (4) @(posedge clk_b);
        #2;
        check("maxrate_rise", 32'(rise0 - snap_r), 32'(5));
        check("maxrate_fall", 32'(fall0 - snap_f), 32'(5));
        check("maxrate_b",    32'(if0.signal_b),   32'(0));

        // Reset pulse while a 0->1 change is still inside the chain.
        snap_r = rise0;
        @(posedge clk_b); #10 if0.signal_a = 1'b1;
        @(posedge clk_b); #10 rst0_n = 1'b0;
        #1 check("midrst_b", 32'(if0.signal_b), 32'(0));
        #4 rst0_n = 1'b1;
        @(posedge clk_b); #2 check("midrst_e1", 32'(if0.signal_b), 32'(0));
        @(posedge clk_b); #2 check("midrst_e2", 32'(if0.signal_b), 32'(1));
        repeat (3) @(posedge clk_b);
        #2 check("midrst_rise", 32'(rise0 - snap_r), 32'(1));

        // Instance 1: held in reset so far, should sit at 1.
        check("d1_rst_b", 32'(if1.signal_b), 32'(1));
        @(posedge clk_b); #5 if1.signal_a = 1'b1;
        @(posedge clk_b); #10 rst1_n = 1'b1;
        repeat (4) @(posedge clk_b);
        #2 check("d1_idle_b", 32'(if1.signal_b), 32'(1));
        snap_f = fall1;
        @(posedge clk_b); #10 if1.signal_a = 1'b0;
        @(posedge clk_b); #2 check("d1_e1", 32'(if1.signal_b), 32'(1));
        @(posedge clk_b); #2 check("d1_e2", 32'(if1.signal_b), 32'(1));
        @(posedge clk_b); #2 check("d1_e3", 32'(if1.signal_b), 32'(0));
        check("d1_e3_fall", 32'(if1.signal_b_fall), 32'(1));
        repeat (3) @(posedge clk_b);
        #2 check("d1_fall_cnt", 32'(fall1 - snap_f), 32'(1));
        check("d1_rise_cnt", 32'(rise1), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/single_bit_sync.md
# single_bit_sync

Two-or-more-flop level synchronizer carrying one quasi-static control bit from an unrelated source clock domain into the `clk_b` domain. It sits at the destination side of a clock-domain crossing. Alongside the synchronized level it provides single-cycle rise and fall strobes. The source signal must already be registered in its own domain; this block contains no logic clocked by the source clock.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: number of synchronizer flops in series. Legal range 2..8; values below 2 are a compile-time error.
- `RESET_VALUE`, default 1'b0: value loaded into every synchronizer flop and the edge-detect history flop on reset.

Ports:
- `clk_b`  input  1: destination-domain clock, rising-edge active. This is the only clock in the block.
- `rst_n`  input  1: asynchronous active-low reset. Assertion is asynchronous; release must be synchronous to `clk_b`.
- `signal_a`  input  1: asynchronous level from the source domain. It must be glitch-free, meaning driven directly from a source-domain flop.
- `signal_b`  output  1: synchronized copy of `signal_a`, taken from the last synchronizer stage.
- `signal_b_rise`  output  1: one-`clk_b`-cycle pulse on each 0→1 transition of `signal_b`.
- `signal_b_fall`  output  1: one-`clk_b`-cycle pulse on each 1→0 transition of `signal_b`.

## Operation
- Shift chain `sync[0..SYNC_STAGES-1]`:
  - On each `clk_b` rising edge, `sync[0]` ← `signal_a` and `sync[i]` ← `sync[i-1]`.
  - `signal_b` = `sync[SYNC_STAGES-1]`.
- Only `sync[0]` may sample `signal_a`. No combinational logic is allowed between `signal_a` and `sync[0]`, or between any two stages.
- Mark all `sync[*]` flops as synchronizer cells so tools keep them adjacent and do not retime or duplicate them.
- History flop `prev_b` ← `signal_b` each cycle.
  - `signal_b_rise` = `signal_b & ~prev_b`.
  - `signal_b_fall` = `~signal_b & prev_b`.
  - Both are registered-equivalent: they depend only on flop outputs, with no path from `signal_a`.
- Reset (`rst_n`=0) immediately sets all `sync[*]` and `prev_b` to `RESET_VALUE`. Result: `signal_b`=`RESET_VALUE` and `signal_b_rise`=`signal_b_fall`=0.
- Reset asserted mid-transfer: any in-flight value is discarded. After release, the chain refills from `signal_a` and needs the full `SYNC_STAGES` latency.
- Pulse-width requirement on `signal_a`:
  - A level is guaranteed to propagate only if it is held for at least one `clk_b` period plus setup/hold.
  - Shorter pulses may be lost. This is legal and is not an error.
- Metastability: `sync[0]` may go metastable. Later stages resolve it, and `signal_b` is always a clean 0 or 1. A transition landing in the setup/hold window of `sync[0]` may show up one cycle early or one cycle late, but never as a glitch.

## Timing
- Latency from a `signal_a` change to `signal_b`: `SYNC_STAGES` to `SYNC_STAGES`+1 rising edges of `clk_b`, counting from the first edge after the change.
  - With the default of 2, the change appears on the 2nd `clk_b` edge after `signal_a` settles.
- `signal_b_rise` / `signal_b_fall` go high in the same cycle `signal_b` changes and stay high for exactly one `clk_b` cycle.
- Rise and fall strobes are never high in the same cycle.
- Back-to-back toggles of `signal_a` spaced ≥1 `clk_b` period apart all appear on `signal_b`, in order, with no merging.
- Throughput: one transition per `clk_b` cycle maximum on `signal_b`.
- Outputs change only on `clk_b` rising edges, or asynchronously on `rst_n` assertion.

## Test plan
The bench uses `clk_b` with a 30 ns period (posedges at 15, 45, 75, … ns) and `SYNC_STAGES`=2.
- Reset: hold `rst_n`=0 while `signal_a` toggles → `signal_b`=0 and `signal_b_rise`=`signal_b_fall`=0 throughout. Release at 40 ns with `signal_a`=1 → `signal_b`=1 at the 75 ns edge.
- Basic sequence: `signal_a`=1 at 25 ns, 0 at 65 ns, 1 at 95 ns → `signal_b` rises at 75 ns, falls at 105 ns, rises at 135 ns. A rise strobe is high during 75–105 ns, a fall strobe during 105–135 ns, and another rise strobe during 135–165 ns.
- Short pulse: a 5 ns `signal_a` high pulse placed between `clk_b` edges → `signal_b` stays 0 and no strobes fire.
- Max-rate toggling: toggle `signal_a` once per 30 ns, offset 10 ns from the edges → `signal_b` reproduces every toggle delayed by 2 cycles, with one strobe per transition.
- Mid-transfer reset: `signal_a` 0→1, then pulse `rst_n` low for 5 ns one edge later → `signal_b` stays 0 through reset. It reaches 1 two edges after release, with `signal_b_rise` firing once.
- Parameter sweep: `SYNC_STAGES`=3 with `RESET_VALUE`=1 → after reset `signal_b`=1; when `signal_a` goes 0, `signal_b` follows 3 edges later and `signal_b_fall` pulses once.
